hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Producer-side counterpart to the EX-stage forwarding logic. Detects the hazards that forwarding cannot resolve and drives the pipeline stall and flush controls.
- Hazards covered: load-use, branch-compare-in-ID dependencies, and reads of HI/LO or a new mult/div issue while the multi-cycle multiply/divide unit is busy.
- Also generates the 1-bit ID-stage forwarding selects for the branch comparator.
- Sits beside the 5-stage MIPS datapath and owns the mult/div occupancy FSM.

Parameters:
- MULT_CYCLES, 4, EX-side busy cycles for mult/multu (minimum 1).
- DIV_CYCLES, 32, EX-side busy cycles for div/divu (minimum 1).
- CNT_W, $clog2(DIV_CYCLES+1), busy counter width (derived localparam).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs_D  input  5  Rs of the instruction in ID.
- rt_D  input  5  Rt of the instruction in ID.
- branch_D  input  1  ID instruction is beq/bne (comparison done in ID).
- hilo_read_D  input  1  ID instruction is mfhi/mflo.
- md_start_D  input  1  ID instruction is mult/multu/div/divu.
- write_reg_E  input  5  destination register of the EX instruction.
- reg_write_E  input  1  EX instruction writes the register file.
- mem_to_reg_E  input  1  EX instruction is a load.
- md_start_E  input  1  EX instruction issues mult/div this cycle.
- md_op_E  input  1  0 = multiply, 1 = divide.
- write_reg_M  input  5  destination register of the MEM instruction.
- reg_write_M  input  1  MEM instruction writes the register file.
- mem_to_reg_M  input  1  MEM instruction is a load.
- stall_F  output  1  hold the PC.
- stall_D  output  1  hold the IF/ID register.
- flush_E  output  1  clear the ID/EX register (insert bubble).
- forward_a_D  output  1  branch comparator A takes the MEM ALU result.
- forward_b_D  output  1  branch comparator B takes the MEM ALU result.
- md_busy  output  1  mult/div unit is occupied.
- md_done  output  1  one-cycle pulse: HI/LO written at the end of this cycle.

Behaviour:
- Register-match helper: match(w, en, r) = en && (w != 0) && (w == r). Register $0 never causes a hazard or a forward.
- forward_a_D = match(write_reg_M, reg_write_M, rs_D).
- forward_b_D = match(write_reg_M, reg_write_M, rt_D).
- lw_stall = mem_to_reg_E && (match(write_reg_E, reg_write_E, rs_D) || match(write_reg_E, reg_write_E, rt_D)).
- br_stall = branch_D && (match(write_reg_E, reg_write_E, rs_D or rt_D) || (mem_to_reg_M && match(write_reg_M, reg_write_M, rs_D or rt_D))).
- md_stall = (hilo_read_D || md_start_D) && (state != IDLE).
- stall = lw_stall | br_stall | md_stall.
  - stall_F = stall_D = flush_E = stall.
  - These outputs are combinational with zero latency.
- FSM states: IDLE, BUSY, DONE. The counter cnt is CNT_W bits wide.
  - IDLE: on md_start_E, go to BUSY and load cnt = (md_op_E ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: if cnt == 0, go to DONE; otherwise decrement cnt. Net result: md_busy is high for exactly LAT cycles after the start edge.
  - DONE: md_done = 1 for one cycle, then go to IDLE. A start in DONE cannot occur because D is stalled.
  - md_start_E while in BUSY or DONE is ignored; the bench flags it as a protocol error.
- Output decode: md_busy = (state == BUSY); md_done = (state == DONE).
- Reset:
  - rst_n low forces state = IDLE and cnt = 0 immediately (asynchronous), so md_busy = md_done = 0.
  - stall_F, stall_D and forward_* are forced to 0 during reset; flush_E is forced to 1.
  - Reset mid-operation abandons the divide; no md_done is produced.
- Simultaneous events:
  - lw_stall and md_stall together assert a single stall; there is no priority effect.
  - md_done and a hilo_read_D in the same cycle still stall. The read proceeds in the following IDLE cycle.
  - The flush from a stall never cancels an md_start_E already in EX.

Decomposition:
- Shared package holds:
  - md FSM state enum (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - REG_ZERO = 5'd0;
  - default MULT_CYCLES and DIV_CYCLES.
- One sub-module, md_occupancy_tracker, contains the FSM and counter and outputs md_busy and md_done. The hazard comparisons remain in the top-level module.

Test Plan:
- lw $8 in EX (write_reg_E=8, mem_to_reg_E=1, reg_write_E=1), add with rs_D=8 -> stall_F=stall_D=flush_E=1. Next cycle, with the load in MEM and the ID operands unchanged -> all 0.
- beq rs_D=9, with write_reg_M=9 and reg_write_M=1 (ALU op) -> forward_a_D=1, stall=0. With write_reg_E=9 and reg_write_E=1 -> stall=1, forward_a_D=0.
- Destination $0: write_reg_E=0, mem_to_reg_E=1, rs_D=0 -> no stall. write_reg_M=0, rs_D=0, reg_write_M=1 -> forward_a_D=0.
- md_start_E=1, md_op_E=0 -> md_busy high for 4 cycles, then md_done high for 1 cycle. hilo_read_D held high throughout -> stall=1 for all 5 cycles, 0 on the 6th.
- div start (md_op_E=1); rst_n pulled low asynchronously at busy cycle 10 -> md_busy drops immediately, no md_done pulse. After release, the FSM is in IDLE and a new mult completes in 4+1 cycles.
- lw_stall and md_stall asserted together -> single stall; md_start_E presented during BUSY -> ignored, md_done timing unchanged.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared types and defaults for the MIPS hazard control unit and its mult/div occupancy tracker.
// Latency: none (declarations only); backpressure: none.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_MULT_CYCLES = 4;
  localparam int         DEF_DIV_CYCLES  = 32;

  // $0 is hardwired to zero, so it can never be a real producer.
  function automatic logic reg_match(input logic [4:0] w, input logic en, input logic [4:0] r);
    return en && (w != REG_ZERO) && (w == r);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side view of the hazard unit: ID/EX/MEM register info in, stall/flush/forward controls out.
// Latency: wires only; backpressure: stall_F/stall_D hold the front end, flush_E inserts a bubble.
interface hazard_control_unit_if;

  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic       branch_D;
  logic       hilo_read_D;
  logic       md_start_D;
  logic [4:0] write_reg_E;
  logic       reg_write_E;
  logic       mem_to_reg_E;
  logic       md_start_E;
  logic       md_op_E;
  logic [4:0] write_reg_M;
  logic       reg_write_M;
  logic       mem_to_reg_M;
  logic       stall_F;
  logic       stall_D;
  logic       flush_E;
  logic       forward_a_D;
  logic       forward_b_D;
  logic       md_busy;
  logic       md_done;

  modport master (
    output rs_D, rt_D, branch_D, hilo_read_D, md_start_D,
    output write_reg_E, reg_write_E, mem_to_reg_E, md_start_E, md_op_E,
    output write_reg_M, reg_write_M, mem_to_reg_M,
    input  stall_F, stall_D, flush_E, forward_a_D, forward_b_D, md_busy, md_done
  );

  modport slave (
    input  rs_D, rt_D, branch_D, hilo_read_D, md_start_D,
    input  write_reg_E, reg_write_E, mem_to_reg_E, md_start_E, md_op_E,
    input  write_reg_M, reg_write_M, mem_to_reg_M,
    output stall_F, stall_D, flush_E, forward_a_D, forward_b_D, md_busy, md_done
  );

endinterface

// File: rtl/hazard_control_unit_md_occupancy_tracker.sv
// Tracks multi-cycle mult/div occupancy: md_busy for LAT cycles after the start edge, then a 1-cycle md_done.
// Latency: busy from the edge after md_start_E; backpressure: starts while occupied are ignored.
module md_occupancy_tracker
  import hazard_control_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_E,
  input  logic md_op_E,
  output logic md_busy,
  output logic md_done
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start_E) begin
          state_d = BUSY;
          cnt_d   = md_op_E ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign md_busy = (state_q == BUSY);
  assign md_done = (state_q == DONE);

endmodule

// File: rtl/hazard_control_unit.sv
// Detects load-use, branch-in-ID and mult/div-busy hazards; drives stall/flush and ID branch forwarding.
// Latency: all controls combinational (zero cycles); backpressure: stall holds F/D and bubbles E.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_control_unit_if.slave   hz
);

  logic md_busy;
  logic md_done;
  logic e_hits_rs, e_hits_rt, m_hits_rs, m_hits_rt;
  logic lw_stall, br_stall, md_stall, stall;

  md_occupancy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_occupancy_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_E (hz.md_start_E),
    .md_op_E    (hz.md_op_E),
    .md_busy    (md_busy),
    .md_done    (md_done)
  );

  assign e_hits_rs = reg_match(hz.write_reg_E, hz.reg_write_E, hz.rs_D);
  assign e_hits_rt = reg_match(hz.write_reg_E, hz.reg_write_E, hz.rt_D);
  assign m_hits_rs = reg_match(hz.write_reg_M, hz.reg_write_M, hz.rs_D);
  assign m_hits_rt = reg_match(hz.write_reg_M, hz.reg_write_M, hz.rt_D);

  assign lw_stall = hz.mem_to_reg_E && (e_hits_rs || e_hits_rt);
  // A branch compares in ID, so any EX result and a MEM load are both too late to forward.
  assign br_stall = hz.branch_D &&
                    ((e_hits_rs || e_hits_rt) || (hz.mem_to_reg_M && (m_hits_rs || m_hits_rt)));
  assign md_stall = (hz.hilo_read_D || hz.md_start_D) && (md_busy || md_done);
  assign stall    = lw_stall || br_stall || md_stall;

  // During reset the front end runs free and EX is held as a bubble.
  assign hz.stall_F     = rst_n && stall;
  assign hz.stall_D     = rst_n && stall;
  assign hz.flush_E     = !rst_n || stall;
  assign hz.forward_a_D = rst_n && m_hits_rs;
  assign hz.forward_b_D = rst_n && m_hits_rt;
  assign hz.md_busy     = md_busy;
  assign hz.md_done     = md_done;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: stimulus pushes expected controls, a negedge monitor pops and compares.
module tb_hazard_control_unit;

  logic clk;
  logic rst_n;

  hazard_control_unit_if hz ();

  hazard_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] v;   // {stall_F, stall_D, flush_E, forward_a_D, forward_b_D, md_busy, md_done}
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {hz.stall_F, hz.stall_D, hz.flush_E, hz.forward_a_D, hz.forward_b_D,
             hz.md_busy, hz.md_done};
      n_cmp++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got sF/sD/fE/fa/fb/busy/done=%b expected %b at %0t", e.name, act, e.v, $time);
      end
    end
  end

  task automatic clr();
    hz.rs_D = 5'd0; hz.rt_D = 5'd0; hz.branch_D = 1'b0; hz.hilo_read_D = 1'b0; hz.md_start_D = 1'b0;
    hz.write_reg_E = 5'd0; hz.reg_write_E = 1'b0; hz.mem_to_reg_E = 1'b0;
    hz.md_start_E = 1'b0; hz.md_op_E = 1'b0;
    hz.write_reg_M = 5'd0; hz.reg_write_M = 1'b0; hz.mem_to_reg_M = 1'b0;
  endtask

  // Push the expectation for the vector currently driven, then advance one cycle.
  task automatic apply(input string name, input logic s, input logic f, input logic fa,
                       input logic fb, input logic bz, input logic dn);
    exp_t e;
    if (hz.md_start_E && (bz || dn))
      $display("protocol: md_start_E presented while mult/div occupied (%s), expected to be ignored", name);
    e.name = name;
    e.v    = {s, s, f, fa, fb, bz, dn};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input string name, input logic s, input logic fa, input logic fb,
                    input logic bz, input logic dn);
    apply(name, s, s, fa, fb, bz, dn);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Hazard-looking inputs during reset must be masked; flush held high.
    hz.rs_D = 5'd5; hz.rt_D = 5'd6; hz.write_reg_M = 5'd5; hz.reg_write_M = 1'b1;
    hz.write_reg_E = 5'd6; hz.reg_write_E = 1'b1; hz.mem_to_reg_E = 1'b1;
    apply("reset", 0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    clr(); hz.write_reg_E = 5'd8; hz.reg_write_E = 1'b1; hz.mem_to_reg_E = 1'b1; hz.rs_D = 5'd8;
    ap("lw_use_rs", 1, 0, 0, 0, 0);
    clr(); hz.write_reg_M = 5'd8; hz.reg_write_M = 1'b1; hz.mem_to_reg_M = 1'b1; hz.rs_D = 5'd8;
    ap("lw_in_mem", 0, 1, 0, 0, 0);
    clr(); hz.write_reg_E = 5'd3; hz.reg_write_E = 1'b1; hz.mem_to_reg_E = 1'b1; hz.rs_D = 5'd1; hz.rt_D = 5'd3;
    ap("lw_use_rt", 1, 0, 0, 0, 0);
    clr(); hz.write_reg_E = 5'd8; hz.reg_write_E = 1'b1; hz.rs_D = 5'd8;
    ap("alu_in_ex", 0, 0, 0, 0, 0);
    clr(); hz.branch_D = 1'b1; hz.rs_D = 5'd9; hz.write_reg_M = 5'd9; hz.reg_write_M = 1'b1;
    ap("beq_fwd_m", 0, 1, 0, 0, 0);
    clr(); hz.branch_D = 1'b1; hz.rs_D = 5'd9; hz.write_reg_E = 5'd9; hz.reg_write_E = 1'b1;
    ap("beq_dep_e", 1, 0, 0, 0, 0);
    clr(); hz.branch_D = 1'b1; hz.rs_D = 5'd2; hz.rt_D = 5'd7;
    hz.write_reg_M = 5'd7; hz.reg_write_M = 1'b1; hz.mem_to_reg_M = 1'b1;
    ap("beq_load_m", 1, 0, 1, 0, 0);
    clr(); hz.branch_D = 1'b1; hz.rs_D = 5'd0; hz.write_reg_E = 5'd0; hz.reg_write_E = 1'b1;
    hz.mem_to_reg_E = 1'b1; hz.write_reg_M = 5'd0; hz.reg_write_M = 1'b1;
    ap("reg_zero", 0, 0, 0, 0, 0);
    clr(); hz.rs_D = 5'd4; hz.rt_D = 5'd12; hz.write_reg_M = 5'd12; hz.reg_write_M = 1'b1;
    ap("fwd_b", 0, 0, 1, 0, 0);

    // Multiply with mfhi waiting in ID.
    clr(); hz.md_start_E = 1'b1; hz.md_op_E = 1'b0;
    ap("mul_start", 0, 0, 0, 0, 0);
    clr(); hz.hilo_read_D = 1'b1;
    for (int i = 0; i < 4; i++) ap("mul_busy", 1, 0, 0, 1, 0);
    ap("mul_done", 1, 0, 0, 0, 1);
    ap("mul_after", 0, 0, 0, 0, 0);

    // Divide abandoned by reset at busy cycle 10.
    clr(); hz.md_start_E = 1'b1; hz.md_op_E = 1'b1;
    ap("div_start", 0, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 9; i++) ap("div_busy", 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    apply("div_reset", 0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    ap("post_rst_idle0", 0, 0, 0, 0, 0);
    ap("post_rst_idle1", 0, 0, 0, 0, 0);
    hz.md_start_E = 1'b1;
    ap("mul2_start", 0, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 4; i++) ap("mul2_busy", 0, 0, 0, 1, 0);
    ap("mul2_done", 0, 0, 0, 0, 1);
    ap("mul2_after", 0, 0, 0, 0, 0);

    // Overlapping load-use and mult/div stalls; a stray start during BUSY.
    hz.md_start_E = 1'b1;
    ap("mul3_start", 0, 0, 0, 0, 0);
    clr(); hz.hilo_read_D = 1'b1; hz.write_reg_E = 5'd8; hz.reg_write_E = 1'b1;
    hz.mem_to_reg_E = 1'b1; hz.rs_D = 5'd8;
    ap("lw_and_md", 1, 0, 0, 1, 0);
    clr(); hz.md_start_E = 1'b1; hz.md_op_E = 1'b1; hz.md_start_D = 1'b1;
    ap("start_in_busy", 1, 0, 0, 1, 0);
    clr(); hz.hilo_read_D = 1'b1;
    ap("mul3_busy3", 1, 0, 0, 1, 0);
    ap("mul3_busy4", 1, 0, 0, 1, 0);
    ap("mul3_done", 1, 0, 0, 0, 1);
    ap("mul3_after", 0, 0, 0, 0, 0);
    clr();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
